iot_event_serializer: RTL and testbench

IOT_EVENT_SERIALIZER -- requirements
Module: iot_event_serializer

---
 rtl/iot_event_serializer_if.sv | 29 ++
 rtl/iot_event_serializer.sv | 114 +++++++++++
 tb/tb_iot_event_serializer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/iot_event_serializer_if.sv
// ============================================================================
// iot_event_serializer_if : device event inputs and serialized event outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface iot_event_serializer_if;
  logic [3:0] dev_on;
  logic [3:0] dev_off;
  logic       change;
  logic       on_off;
  logic [1:0] dev_id;
  logic [3:0] active_mask;
  logic       err;

  // master: the event producer / monitor side
  modport master (
    output dev_on, dev_off,
    input  change, on_off, dev_id, active_mask, err
  );

  // slave: the serializer itself
  modport slave (
    input  dev_on, dev_off,
    output change, on_off, dev_id, active_mask, err
  );
endinterface

`default_nettype wire

// File: rtl/iot_event_serializer.sv
// ============================================================================
// iot_event_serializer : queues per-device connect/disconnect events and
// issues them one per cycle in round-robin order.  Rev 1.0
// ============================================================================
`default_nettype none

module iot_event_serializer (
  input wire logic              clk,
  input wire logic              rst,
  iot_event_serializer_if.slave bus
);

  logic [3:0] active_q,   active_d;
  logic [3:0] pending_q,  pending_d;
  logic [3:0] pend_dir_q, pend_dir_d;
  logic [1:0] ptr_q,      ptr_d;
  logic       change_q,   change_d;
  logic       on_off_q,   on_off_d;
  logic [1:0] dev_id_q,   dev_id_d;
  logic       err_q,      err_d;

  logic       grant_vld;
  logic [1:0] grant_id;
  logic [1:0] idx;
  logic       target;
  logic       eff;

  // Round-robin pick: scan offsets high-to-low so the closest one to ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ptr_q;
    idx       = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (pending_q[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    active_d   = active_q;
    pending_d  = pending_q;
    pend_dir_d = pend_dir_q;
    ptr_d      = ptr_q;
    change_d   = grant_vld;
    on_off_d   = on_off_q;
    dev_id_d   = dev_id_q;
    err_d      = 1'b0;
    target     = 1'b0;
    eff        = 1'b0;

    if (grant_vld) begin
      on_off_d           = pend_dir_q[grant_id];
      dev_id_d           = grant_id;
      active_d[grant_id] = pend_dir_q[grant_id];
      pending_d[grant_id] = 1'b0;
      ptr_d              = grant_id + 2'd1;
    end

    // New events are judged against the state left after this edge's grant.
    for (int i = 0; i < 4; i++) begin
      if (bus.dev_on[i] && bus.dev_off[i]) begin
        err_d = 1'b1;
      end else if (bus.dev_on[i] ^ bus.dev_off[i]) begin
        target = bus.dev_on[i];
        eff    = pending_d[i] ? pend_dir_d[i] : active_d[i];
        if (target == active_d[i]) begin
          if (!pending_d[i]) begin
            err_d = 1'b1;
          end
          pending_d[i] = 1'b0;
        end else if (target != eff) begin
          pending_d[i]  = 1'b1;
          pend_dir_d[i] = target;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q   <= 4'd0;
      pending_q  <= 4'd0;
      pend_dir_q <= 4'd0;
      ptr_q      <= 2'd0;
      change_q   <= 1'b0;
      on_off_q   <= 1'b0;
      dev_id_q   <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_dir_q <= pend_dir_d;
      ptr_q      <= ptr_d;
      change_q   <= change_d;
      on_off_q   <= on_off_d;
      dev_id_q   <= dev_id_d;
      err_q      <= err_d;
    end
  end

  assign bus.change      = change_q;
  assign bus.on_off      = on_off_q;
  assign bus.dev_id      = dev_id_q;
  assign bus.active_mask = active_q;
  assign bus.err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_iot_event_serializer.sv
// ============================================================================
// tb_iot_event_serializer : directed vectors with hand-computed expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_iot_event_serializer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  iot_event_serializer_if bus_if ();

  iot_event_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Alternating device 0 / device 3 script, one entry per clock edge.
  logic [3:0] fair_on   [0:9] = '{4'b1000, 4'b0000, 4'b0001, 4'b1000, 4'b0000,
                                  4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] fair_off  [0:9] = '{4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0001,
                                  4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic       fair_chg  [0:9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] fair_id   [0:9] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0,
                                  2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
  logic       fair_oo   [0:9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] on_v, input logic [3:0] off_v);
    bus_if.dev_on  = on_v;
    bus_if.dev_off = off_v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_change"}, 32'(bus_if.change), 32'd0);
    chk({tag, "_on_off"}, 32'(bus_if.on_off), 32'd0);
    chk({tag, "_dev_id"}, 32'(bus_if.dev_id), 32'd0);
    chk({tag, "_mask"},   32'(bus_if.active_mask), 32'd0);
    chk({tag, "_err"},    32'(bus_if.err), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    drive(4'b1111, 4'b0000);

    // Reset with events present: they must be discarded.
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    drive(4'b0000, 4'b0000);
    tick();
    chk("post_reset_change", 32'(bus_if.change), 32'd0);
    tick();
    chk("post_reset_change2", 32'(bus_if.change), 32'd0);

    // Single connect on device 2.
    drive(4'b0100, 4'b0000);
    tick();
    chk("single_latency_change", 32'(bus_if.change), 32'd0);
    drive(4'b0000, 4'b0000);
    tick();
    chk("single_change", 32'(bus_if.change), 32'd1);
    chk("single_on_off", 32'(bus_if.on_off), 32'd1);
    chk("single_dev_id", 32'(bus_if.dev_id), 32'd2);
    chk("single_mask",   32'(bus_if.active_mask), 32'd4);
    tick();
    chk("single_done", 32'(bus_if.change), 32'd0);

    // Reset to bring ptr back to 0, then a 4-device burst with a queued duplicate.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(4'b1111, 4'b0000);
    tick();
    chk("burst_latency", 32'(bus_if.change), 32'd0);
    drive(4'b1000, 4'b0000);
    tick();
    chk("burst0_change", 32'(bus_if.change), 32'd1);
    chk("burst0_dev_id", 32'(bus_if.dev_id), 32'd0);
    chk("burst0_on_off", 32'(bus_if.on_off), 32'd1);
    chk("dup_queued_err", 32'(bus_if.err), 32'd1);
    drive(4'b0000, 4'b0000);
    for (int j = 1; j < 4; j++) begin
      tick();
      chk($sformatf("burst%0d_change", j), 32'(bus_if.change), 32'd1);
      chk($sformatf("burst%0d_dev_id", j), 32'(bus_if.dev_id), 32'(j));
      chk($sformatf("burst%0d_on_off", j), 32'(bus_if.on_off), 32'd1);
      chk($sformatf("burst%0d_err", j),    32'(bus_if.err), 32'd0);
    end
    tick();
    chk("burst_end_change", 32'(bus_if.change), 32'd0);
    chk("burst_end_mask",   32'(bus_if.active_mask), 32'hF);

    // Duplicate connect on an active device.
    drive(4'b1000, 4'b0000);
    tick();
    chk("dup_active_err",    32'(bus_if.err), 32'd1);
    chk("dup_active_change", 32'(bus_if.change), 32'd0);
    drive(4'b0000, 4'b0000);
    tick();
    chk("dup_active_err_clr", 32'(bus_if.err), 32'd0);
    chk("dup_active_nochg",   32'(bus_if.change), 32'd0);

    // Simultaneous on and off on device 0.
    drive(4'b0001, 4'b0001);
    tick();
    chk("both_err", 32'(bus_if.err), 32'd1);
    drive(4'b0000, 4'b0000);
    tick();
    chk("both_nochg", 32'(bus_if.change), 32'd0);
    chk("both_mask",  32'(bus_if.active_mask), 32'hF);

    // Reset with three disconnects pending.
    drive(4'b0000, 4'b0111);
    tick();
    rst = 1'b0;
    drive(4'b0000, 4'b0000);
    tick();
    chk_all_zero("midreset");
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("midreset_quiet%0d", j), 32'(bus_if.change), 32'd0);
    end

    // Cancel: device 1 connects then disconnects while device 0 is issued.
    drive(4'b0011, 4'b0000);
    tick();
    drive(4'b0000, 4'b0010);
    tick();
    chk("cancel_grant_change", 32'(bus_if.change), 32'd1);
    chk("cancel_grant_dev_id", 32'(bus_if.dev_id), 32'd0);
    chk("cancel_err",          32'(bus_if.err), 32'd0);
    drive(4'b0000, 4'b0000);
    tick();
    chk("cancel_nochg",  32'(bus_if.change), 32'd0);
    chk("cancel_mask",   32'(bus_if.active_mask), 32'd1);
    chk("cancel_err2",   32'(bus_if.err), 32'd0);
    tick();
    chk("cancel_nochg2", 32'(bus_if.change), 32'd0);

    // Fairness: devices 0 and 3 continuously re-pended.
    for (int e = 0; e < 10; e++) begin
      drive(fair_on[e], fair_off[e]);
      tick();
      chk($sformatf("fair%0d_change", e), 32'(bus_if.change), 32'(fair_chg[e]));
      chk($sformatf("fair%0d_err", e),    32'(bus_if.err), 32'd0);
      if (fair_chg[e]) begin
        chk($sformatf("fair%0d_dev_id", e), 32'(bus_if.dev_id), 32'(fair_id[e]));
        chk($sformatf("fair%0d_on_off", e), 32'(bus_if.on_off), 32'(fair_oo[e]));
      end
    end
    chk("fair_end_mask", 32'(bus_if.active_mask), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
